// File: rtl/piso_shift_tx_pkg.sv
// Shared definitions for the serial shift link: FSM state encoding and the
// bit-counter width helper used by the transmitter and the receiver bench.
package piso_shift_tx_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } tx_state_e;

  // Counter must hold WIDTH-1; clamp so a 1-bit word still gets a 1-bit counter.
  function automatic int cnt_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/piso_shift_tx_if.sv
// Parallel load handshake plus serial output bundle for piso_shift_tx.
interface piso_shift_tx_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             load_valid;
  logic [WIDTH-1:0] load_data;
  logic             load_ready;
  logic             sout;
  logic             sout_valid;
  logic             last;
  logic             busy;

  modport master (
    output en, load_valid, load_data,
    input  load_ready, sout, sout_valid, last, busy
  );

  modport slave (
    input  en, load_valid, load_data,
    output load_ready, sout, sout_valid, last, busy
  );
endinterface

// File: rtl/piso_shift_tx_bit_counter.sv
// Loadable down-counter with enable and zero flag; tracks bits left in a word.
module tx_bit_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  assign zero = (count == '0);

  // NOTE: sequential state is always updated with non-blocking assignments so
  // every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && !zero) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/piso_shift_tx.sv
// Parallel-in serial-out transmitter: accepts a word on valid/ready and shifts
// it out one bit per enabled clock, with registered sout/sout_valid/last.
module piso_shift_tx
  import piso_shift_tx_pkg::*;
#(
  parameter int   WIDTH      = 4,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  piso_shift_tx_if.slave  tx
);

  localparam int               CNT_W    = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  tx_state_e        state;
  logic [WIDTH-1:0] shreg;
  logic             sout_q;
  logic             sout_valid_q;
  logic             last_q;

  logic [CNT_W-1:0] count;
  logic             cnt_zero;
  logic             load_ready;
  logic             handshake;
  logic             shift_en;

  logic             first_bit;
  logic             next_bit;
  logic [WIDTH-1:0] shreg_shifted;

  // Ready during the last enabled bit so a follow-on word streams without a gap.
  assign load_ready = (state == ST_IDLE) || ((state == ST_SHIFT) && last_q && tx.en);
  assign handshake  = tx.load_valid && load_ready;
  assign shift_en   = (state == ST_SHIFT) && tx.en;

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    first_bit     = 1'b0;
    next_bit      = 1'b0;
    shreg_shifted = shreg;
    if (MSB_FIRST) begin
      first_bit     = tx.load_data[WIDTH-1];
      next_bit      = shreg[WIDTH-2];
      shreg_shifted = shreg << 1;
    end else begin
      first_bit     = tx.load_data[0];
      next_bit      = shreg[1];
      shreg_shifted = shreg >> 1;
    end
  end

  tx_bit_counter #(
    .CNT_W (CNT_W)
  ) u_bit_counter (
    .clk        (clk),
    .rst        (rst),
    .load       (handshake),
    .load_value (CNT_INIT),
    .dec        (shift_en),
    .count      (count),
    .zero       (cnt_zero)
  );

  // sout is always the bit at the head of shreg; loading presents the word's
  // first bit immediately, each shift presents the one behind it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      shreg        <= '0;
      sout_q       <= IDLE_LEVEL;
      sout_valid_q <= 1'b0;
      last_q       <= 1'b0;
    end else if (handshake) begin
      state        <= ST_SHIFT;
      shreg        <= tx.load_data;
      sout_q       <= first_bit;
      sout_valid_q <= 1'b1;
      last_q       <= 1'b0;
    end else if (shift_en) begin
      if (cnt_zero) begin
        state        <= ST_IDLE;
        sout_q       <= IDLE_LEVEL;
        sout_valid_q <= 1'b0;
        last_q       <= 1'b0;
      end else begin
        shreg  <= shreg_shifted;
        sout_q <= next_bit;
        last_q <= (count == CNT_ONE);
      end
    end
  end

  assign tx.load_ready = load_ready;
  assign tx.sout       = sout_q;
  assign tx.sout_valid = sout_valid_q;
  assign tx.last       = last_q;
  assign tx.busy       = (state == ST_SHIFT);

endmodule

// File: tb/tb_piso_shift_tx.sv
// Self-checking bench: two transmitters (4-bit MSB-first, 8-bit LSB-first)
// compared every cycle against a bit-queue model of the serial stream.
module tb_piso_shift_tx;

  logic clk;
  logic rst;

  piso_shift_tx_if #(.WIDTH(4)) if_a ();
  piso_shift_tx_if #(.WIDTH(8)) if_b ();

  piso_shift_tx #(.WIDTH(4), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_a (
    .clk (clk),
    .rst (rst),
    .tx  (if_a)
  );

  piso_shift_tx #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_b (
    .clk (clk),
    .rst (rst),
    .tx  (if_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: the bits still to appear on sout, head = bit on sout right now.
  bit         qa[$];
  bit         qb[$];
  logic [3:0] pend_a[$];
  logic [7:0] pend_b[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic check_outputs();
    check("a_sout",  if_a.sout,       (qa.size() > 0) ? qa[0] : 1'b0);
    check("a_valid", if_a.sout_valid, qa.size() > 0);
    check("a_last",  if_a.last,       qa.size() == 1);
    check("a_busy",  if_a.busy,       qa.size() > 0);
    check("b_sout",  if_b.sout,       (qb.size() > 0) ? qb[0] : 1'b0);
    check("b_valid", if_b.sout_valid, qb.size() > 0);
    check("b_last",  if_b.last,       qb.size() == 1);
    check("b_busy",  if_b.busy,       qb.size() > 0);
  endtask

  // One clock: drive inputs, check ready, advance model across the edge, check outputs.
  task automatic cycle(input logic ea, input logic eb);
    logic rdy_a, rdy_b, hs_a, hs_b;
    logic [3:0] wa;
    logic [7:0] wb;
    if_a.en         = ea;
    if_b.en         = eb;
    if_a.load_valid = (pend_a.size() > 0);
    if_b.load_valid = (pend_b.size() > 0);
    if_a.load_data  = (pend_a.size() > 0) ? pend_a[0] : 4'($urandom);
    if_b.load_data  = (pend_b.size() > 0) ? pend_b[0] : 8'($urandom);
    #1;
    rdy_a = (qa.size() == 0) || (qa.size() == 1 && ea);
    rdy_b = (qb.size() == 0) || (qb.size() == 1 && eb);
    check("a_ready", if_a.load_ready, rdy_a);
    check("b_ready", if_b.load_ready, rdy_b);
    hs_a = if_a.load_valid && rdy_a;
    hs_b = if_b.load_valid && rdy_b;
    @(posedge clk);
    if (qa.size() > 0 && ea) void'(qa.pop_front());
    if (qb.size() > 0 && eb) void'(qb.pop_front());
    if (hs_a) begin
      wa = pend_a.pop_front();
      for (int i = 3; i >= 0; i--) qa.push_back(wa[i]);
    end
    if (hs_b) begin
      wb = pend_b.pop_front();
      for (int i = 0; i < 8; i++) qb.push_back(wb[i]);
    end
    #1;
    check_outputs();
  endtask

  // Reset asserted between edges; outputs must clear before any clock edge.
  task automatic mid_reset();
    #2;
    if_a.load_valid = 1'b0;
    if_b.load_valid = 1'b0;
    rst = 1'b0;
    #1;
    qa.delete();
    qb.delete();
    pend_a.delete();
    pend_b.delete();
    check("rst_a_ready", if_a.load_ready, 1'b1);
    check("rst_b_ready", if_b.load_ready, 1'b1);
    check_outputs();
    @(posedge clk);
    #1;
    check_outputs();
    #2;
    rst = 1'b1;
  endtask

  initial begin
    logic [3:0] rx;
    logic [7:0] rxb;
    rst             = 1'b0;
    if_a.en         = 1'b0;
    if_b.en         = 1'b0;
    if_a.load_valid = 1'b0;
    if_b.load_valid = 1'b0;
    if_a.load_data  = '0;
    if_b.load_data  = '0;
    #12;
    check("init_a_ready", if_a.load_ready, 1'b1);
    check_outputs();
    rst = 1'b1;

    // Single word 1011 (MSB-first) and 8'h01 (LSB-first), looped into receivers.
    pend_a.push_back(4'b1011);
    pend_b.push_back(8'h01);
    cycle(1'b1, 1'b1);
    rx  = '0;
    rxb = '0;
    for (int i = 0; i < 8; i++) begin
      if (if_a.sout_valid) rx = {rx[2:0], if_a.sout};
      rxb = {if_b.sout, rxb[7:1]};
      cycle(1'b1, 1'b1);
    end
    check("rx_a_word", rx, 4'b1011);
    check("rx_b_word", rxb, 8'h01);

    // Back-to-back words: continuous 8-bit stream on A.
    pend_a.push_back(4'hA);
    pend_a.push_back(4'h5);
    pend_b.push_back(8'hC3);
    pend_b.push_back(8'h5A);
    repeat (20) cycle(1'b1, 1'b1);

    // Stall after the second bit.
    pend_a.push_back(4'b1100);
    cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b1);
    repeat (3) cycle(1'b0, 1'b0);
    repeat (4) cycle(1'b1, 1'b1);

    // Idle handshake with en low is still accepted.
    pend_a.push_back(4'h9);
    cycle(1'b0, 1'b1);
    repeat (5) cycle(1'b1, 1'b1);

    // Abort mid-word, then a fresh word with no leftovers.
    pend_a.push_back(4'hF);
    pend_b.push_back(8'hFF);
    cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b1);
    mid_reset();
    pend_a.push_back(4'h3);
    repeat (6) cycle(1'b1, 1'b1);

    // Randomized traffic with random stalls and one mid-run reset.
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 2) == 0 && pend_a.size() < 3) pend_a.push_back(4'($urandom));
      if ($urandom_range(0, 2) == 0 && pend_b.size() < 3) pend_b.push_back(8'($urandom));
      cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
      if (n == 400) mid_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
